drop_scheduler: RTL

//  Game-flow controller and spawner for the falling-block datapath. Owns the scene FSM
//  (IDLE/PLAY/OVER), spawns blocks into 6 slots with pseudo-random lanes, advances them

---
 rtl/drops_pkg.sv | 49 ++++
 rtl/lfsr16.sv | 24 ++
 rtl/drop_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/drops_pkg.sv
// Shared definitions for the falling-block datapath: scene codes, slot geometry and
// the free-slot priority encoder used by the scheduler, hit checker and renderer.
package drops_pkg;

    typedef enum logic [1:0] {
        SCENE_IDLE = 2'b00,
        SCENE_PLAY = 2'b01,
        SCENE_OVER = 2'b10
    } scene_e;

    localparam int unsigned N_SLOTS    = 6;
    localparam int unsigned Y_W        = 10;
    localparam int unsigned LANE_W     = 2;
    localparam int unsigned SCORE_W    = 16;
    localparam int unsigned LFSR_W     = 16;
    localparam int unsigned SLOT_IDX_W = $clog2(N_SLOTS);
    localparam int unsigned Y_FLOOR    = 480;
    localparam int unsigned PARK       = 1023;
    localparam int unsigned SPEED_PTS  = 8;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic              valid;
        logic [LANE_W-1:0] lane;
        logic [Y_W-1:0]    y;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '{valid: 1'b0, lane: '0, y: Y_W'(PARK)};

    typedef struct packed {
        logic                  found;
        logic [SLOT_IDX_W-1:0] idx;
    } free_t;

    // Lowest-index slot whose valid bit is clear.
    function automatic free_t first_free(input logic [N_SLOTS-1:0] valid);
        free_t f;
        f = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                f.found = 1'b1;
                f.idx   = SLOT_IDX_W'(i);
            end
        end
        return f;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps x^16+x^14+x^13+x^11, shifting right; loads seed on reset.
module lfsr16
    import drops_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic w_fb;

    assign w_fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= seed;
        end else if (en) begin
            q <= {w_fb, q[LFSR_W-1:1]};
        end
    end

endmodule

// File: rtl/drop_scheduler.sv
// Scene FSM plus block spawner/mover for the falling-block game.
// Optional SPEEDUP_EN: fall step grows with score, capped at 4*STEP.
module drop_scheduler
    import drops_pkg::*;
#(
    parameter int unsigned SPAWN_GAP = 40,
    parameter int unsigned STEP      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      hit,
    output logic [1:0]                scene,
    output logic [N_SLOTS*Y_W-1:0]    pos_blocks,
    output logic [N_SLOTS*LANE_W-1:0] blocks,
    output logic [SCORE_W-1:0]        score
);

    localparam int unsigned CNT_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int unsigned SUM_W = Y_W + 1;
    localparam int unsigned RET_W = $clog2(N_SLOTS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPAWN_GAP - 1);

    scene_e               r_scene;
    slot_t                r_slot [N_SLOTS];
    logic [CNT_W-1:0]     r_cnt;
    logic [SCORE_W-1:0]   r_score;

    logic [LFSR_W-1:0]    w_lfsr;
    logic                 w_unused_lfsr;
    logic [SUM_W-1:0]     w_step;
    logic [SUM_W-1:0]     w_ny [N_SLOTS];
    logic [N_SLOTS-1:0]   w_valid;
    logic [N_SLOTS-1:0]   w_retire;
    logic [RET_W-1:0]     w_nret;
    logic [SCORE_W:0]     w_score_sum;
    logic [SCORE_W-1:0]   w_score_next;
    free_t                w_free;
    logic                 w_adv;
    logic                 w_due;
    logic                 w_spawn;
    logic                 w_enter_play;
    logic                 w_enter_idle;

    lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick),
        .seed  (LFSR_SEED),
        .q     (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[LFSR_W-1:LANE_W];

`ifdef SPEEDUP_EN
    localparam int unsigned RAW_W = SCORE_W + 1;
    logic [SCORE_W-1:0] w_bonus;
    logic [RAW_W-1:0]   w_step_raw;

    assign w_bonus    = r_score / SCORE_W'(SPEED_PTS);
    assign w_step_raw = RAW_W'(STEP) + RAW_W'(w_bonus);
    assign w_step     = (w_step_raw > RAW_W'(4 * STEP)) ? SUM_W'(4 * STEP) : SUM_W'(w_step_raw);
`else
    assign w_step = SUM_W'(STEP);
`endif

    assign w_adv        = (r_scene == SCENE_PLAY) && tick && !hit;
    assign w_enter_play = (r_scene == SCENE_IDLE) && start;
    assign w_enter_idle = (r_scene == SCENE_OVER) && start;
    assign w_due        = (r_cnt == CNT_LAST);

    // Next positions, retire flags and retire count, all from start-of-cycle state.
    always_comb begin
        w_nret = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_valid[i]  = r_slot[i].valid;
            w_ny[i]     = SUM_W'(r_slot[i].y) + w_step;
            w_retire[i] = r_slot[i].valid && (w_ny[i] >= SUM_W'(Y_FLOOR));
            w_nret      = w_nret + RET_W'(w_retire[i]);
        end
    end

    assign w_free       = first_free(w_valid);
    assign w_spawn      = w_adv && w_due && w_free.found;
    assign w_score_sum  = (SCORE_W + 1)'(r_score) + (SCORE_W + 1)'(w_nret);
    assign w_score_next = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];

    // Scene FSM; hit in PLAY wins over tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scene <= SCENE_IDLE;
        end else begin
            case (r_scene)
                SCENE_IDLE: if (start) r_scene <= SCENE_PLAY;
                SCENE_PLAY: if (hit)   r_scene <= SCENE_OVER;
                SCENE_OVER: if (start) r_scene <= SCENE_IDLE;
                default:               r_scene <= SCENE_IDLE;
            endcase
        end
    end

    // Slot array: clear on scene entry, otherwise move/retire/spawn per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_slot[i] <= SLOT_EMPTY;
            end
        end else if (w_enter_play || w_enter_idle) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                r_slot[i] <= SLOT_EMPTY;
            end
        end else if (w_adv) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                if (r_slot[i].valid) begin
                    if (w_retire[i]) begin
                        r_slot[i].valid <= 1'b0;
                        r_slot[i].y     <= Y_W'(PARK);
                    end else begin
                        r_slot[i].y     <= w_ny[i][Y_W-1:0];
                    end
                end else if (w_spawn && (w_free.idx == SLOT_IDX_W'(i))) begin
                    r_slot[i].valid <= 1'b1;
                    r_slot[i].lane  <= w_lfsr[LANE_W-1:0];
                    r_slot[i].y     <= '0;
                end
            end
        end
    end

    // Spawn interval counter wraps even when no slot is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_enter_play) begin
            r_cnt <= '0;
        end else if (w_adv) begin
            r_cnt <= w_due ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= '0;
        end else if (w_enter_play) begin
            r_score <= '0;
        end else if (w_adv) begin
            r_score <= w_score_next;
        end
    end

    // Flatten slot registers onto the shared bus layout.
    always_comb begin
        pos_blocks = '0;
        blocks     = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            pos_blocks[i*Y_W +: Y_W]                 = r_slot[i].y;
            blocks[(N_SLOTS-1-i)*LANE_W +: LANE_W]   = r_slot[i].lane;
        end
    end

    assign scene = r_scene;
    assign score = r_score;

endmodule
